counter_2421_sequencer: RTL and testbench

//  Run controller for a decade 2421-code counter (clk/x/reset/res[3:0]/z).

---
 rtl/counter_2421_sequencer_pkg.sv | 29 ++
 rtl/counter_2421_sequencer.sv | 120 ++++++++++++
 tb/tb_counter_2421_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_2421_sequencer_pkg.sv
// Shared definitions for the 2421 decade counter run controller:
// state encoding, 2421 digit codes and the legal-digit check.
package counter_2421_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] D2421_0 = 4'b0000;
  localparam logic [3:0] D2421_1 = 4'b0001;
  localparam logic [3:0] D2421_2 = 4'b0010;
  localparam logic [3:0] D2421_3 = 4'b0011;
  localparam logic [3:0] D2421_4 = 4'b0100;
  localparam logic [3:0] D2421_5 = 4'b1011;
  localparam logic [3:0] D2421_6 = 4'b1100;
  localparam logic [3:0] D2421_7 = 4'b1101;
  localparam logic [3:0] D2421_8 = 4'b1110;
  localparam logic [3:0] D2421_9 = 4'b1111;

  // Codes 0101..1010 never occur in the 2421 counting sequence.
  function automatic logic is_legal_2421(input logic [3:0] d);
    return (d <= D2421_4) || (d >= D2421_5);
  endfunction

endpackage

// File: rtl/counter_2421_sequencer.sv
// Run controller for an external 2421 decade counter: gates count enables,
// tracks decade carries and flags done when the two-digit target is reached.
module counter_2421_sequencer
  import counter_2421_sequencer_pkg::*;
#(
  parameter int unsigned CLR_CYC  = 1,
  parameter int unsigned TENS_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic       ev_in,
  input  logic [3:0] tgt_units,
  input  logic [3:0] tgt_tens,
  input  logic [3:0] cnt_res,
  input  logic       cnt_z,
  output logic       cnt_x,
  output logic       cnt_reset,
  output logic [3:0] tens_cnt,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

  state_t           state, state_nxt;
  logic [CLR_W-1:0] clr_cnt, clr_nxt;
  logic [3:0]       tens_nxt;
  logic [3:0]       tgt_tens_q, tgt_tens_nxt;
  logic [3:0]       tgt_units_q, tgt_units_nxt;
  logic             err_nxt, done_nxt, busy_nxt, cnt_reset_nxt;
  logic             match, tgt_legal;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      tens_cnt    <= 4'd0;
      tgt_tens_q  <= 4'd0;
      tgt_units_q <= 4'd0;
      err         <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      cnt_reset   <= 1'b1;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_nxt;
      tens_cnt    <= tens_nxt;
      tgt_tens_q  <= tgt_tens_nxt;
      tgt_units_q <= tgt_units_nxt;
      err         <= err_nxt;
      done        <= done_nxt;
      busy        <= busy_nxt;
      cnt_reset   <= cnt_reset_nxt;
    end
  end

  // Next state; cnt_x stays combinational so the match cycle can suppress
  // the enable and the counter stops exactly on the target.
  always_comb begin
    state_nxt     = state;
    clr_nxt       = clr_cnt;
    tens_nxt      = tens_cnt;
    tgt_tens_nxt  = tgt_tens_q;
    tgt_units_nxt = tgt_units_q;
    err_nxt       = err;
    done_nxt      = 1'b0;

    tgt_legal = is_legal_2421(tgt_units) && (tgt_tens <= 4'(TENS_MAX));
    match     = (tens_cnt == tgt_tens_q) && (cnt_res == tgt_units_q);
    cnt_x     = (state == RUN) && ev_in && !pause && !match;

    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (tgt_legal) begin
              state_nxt     = CLEAR;
              clr_nxt       = '0;
              tgt_tens_nxt  = tgt_tens;
              tgt_units_nxt = tgt_units;
              err_nxt       = 1'b0;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        CLEAR: begin
          tens_nxt = 4'd0;
          if (clr_cnt == CLR_LAST) state_nxt = RUN;
          else                     clr_nxt   = clr_cnt + CLR_W'(1);
        end
        RUN: begin
          if (cnt_x && cnt_z) tens_nxt = tens_cnt + 4'd1;
          if (match) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else if (pause) begin
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (!pause) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt      = (state_nxt == CLEAR) || (state_nxt == RUN) || (state_nxt == HOLD);
    cnt_reset_nxt = (state_nxt == IDLE) || (state_nxt == CLEAR);
  end

endmodule

// File: tb/tb_counter_2421_sequencer.sv
// Bench: sequencer paired with a behavioural 2421 decade counter; table of
// whole runs plus hand sequences for latency, abort and reset-mid-run.
module tb_counter_2421_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort, ev_in;
  logic [3:0] tgt_units, tgt_tens;
  logic [3:0] tb_res;
  logic       cnt_z, cnt_x, cnt_reset, busy, done, err;
  logic [3:0] tens_cnt;

  int ntests = 0;
  int nfail  = 0;
  int xpulses = 0;
  int dones = 0;
  int holdviol = 0;

  always #5 clk = ~clk;

  counter_2421_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .ev_in(ev_in), .tgt_units(tgt_units), .tgt_tens(tgt_tens),
    .cnt_res(tb_res), .cnt_z(cnt_z), .cnt_x(cnt_x), .cnt_reset(cnt_reset),
    .tens_cnt(tens_cnt), .busy(busy), .done(done), .err(err)
  );

  // Behavioural 2421 decade counter
  function automatic logic [3:0] next2421(input logic [3:0] d);
    case (d)
      4'b0000: return 4'b0001;
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0011;
      4'b0011: return 4'b0100;
      4'b0100: return 4'b1011;
      4'b1011: return 4'b1100;
      4'b1100: return 4'b1101;
      4'b1101: return 4'b1110;
      4'b1110: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cnt_reset)  tb_res <= 4'b0000;
    else if (cnt_x) tb_res <= next2421(tb_res);
  end
  assign cnt_z = cnt_x && (tb_res == 4'b1111);

  always @(negedge clk) begin
    if (cnt_x === 1'b1) xpulses++;
    if (done === 1'b1) dones++;
    if (pause && cnt_x === 1'b1) holdviol++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] tens;
    logic [3:0] units;
    bit         toggle;
    int         pause_at;
    int         limit;
    bit         exp_done;
    int         exp_cnt;
    logic [3:0] exp_tens;
    logic [3:0] exp_res;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base, dbase, hbase, cyc;
    bit finished, found;

    vecs[0] = '{4'd2, 4'b1101, 1'b0, 0, 400, 1'b1, 27, 4'd2, 4'b1101, 1'b0};
    vecs[1] = '{4'd0, 4'b0000, 1'b0, 0, 400, 1'b1,  0, 4'd0, 4'b0000, 1'b0};
    vecs[2] = '{4'd1, 4'b1011, 1'b1, 8, 400, 1'b1, 15, 4'd1, 4'b1011, 1'b0};
    vecs[3] = '{4'd0, 4'b0110, 1'b0, 0,   6, 1'b0,  0, 4'd0, 4'b0000, 1'b1};
    vecs[4] = '{4'd0, 4'b1111, 1'b0, 0, 400, 1'b1,  9, 4'd0, 4'b1111, 1'b0};
    vecs[5] = '{4'd10, 4'b0000, 1'b0, 0,  6, 1'b0,  0, 4'd0, 4'b0000, 1'b1};
    vecs[6] = '{4'd1, 4'b0000, 1'b0, 0, 400, 1'b1, 10, 4'd1, 4'b0000, 1'b0};
    vecs[7] = '{4'd9, 4'b1111, 1'b0, 0, 400, 1'b1, 99, 4'd9, 4'b1111, 1'b0};

    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; ev_in = 1'b0;
    tgt_units = 4'd0; tgt_tens = 4'd0;
    #50 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cnt_x", 32'(cnt_x), 0);
    check("rst_cnt_reset", 32'(cnt_reset), 1);
    check("rst_tens", 32'(tens_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);

    // Whole-run table
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      tgt_tens = vecs[v].tens; tgt_units = vecs[v].units; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base = xpulses; dbase = dones; hbase = holdviol;
      cyc = 0; finished = 1'b0;
      while (cyc < vecs[v].limit && !finished) begin
        ev_in = vecs[v].toggle ? ((cyc / 2) % 2 == 0) : 1'b1;
        pause = (vecs[v].pause_at != 0) && (cyc >= vecs[v].pause_at) &&
                (cyc < vecs[v].pause_at + 3);
        @(negedge clk);
        if (done) finished = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
      pause = 1'b0; ev_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 ev_in = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_finished", v), 32'(finished), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_counts", v), 32'(xpulses - base), 32'(vecs[v].exp_cnt));
      check($sformatf("v%0d_dones", v), 32'(dones - dbase), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_busy", v), 32'(busy), 0);
      check($sformatf("v%0d_holdviol", v), 32'(holdviol - hbase), 0);
      if (vecs[v].exp_done) begin
        check($sformatf("v%0d_tens", v), 32'(tens_cnt), 32'(vecs[v].exp_tens));
        check($sformatf("v%0d_res", v), 32'(tb_res), 32'(vecs[v].exp_res));
      end
    end

    // Target 00 latency: CLEAR, RUN, then done pulse
    @(posedge clk); #1;
    tgt_tens = 4'd0; tgt_units = 4'b0000; start = 1'b1; ev_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base = xpulses;
    @(negedge clk);
    check("lat_clear_busy", 32'(busy), 1);
    check("lat_clear_rst", 32'(cnt_reset), 1);
    @(negedge clk);
    check("lat_run_busy", 32'(busy), 1);
    check("lat_run_rst", 32'(cnt_reset), 0);
    check("lat_run_done", 32'(done), 0);
    check("lat_run_x", 32'(cnt_x), 0);
    @(negedge clk);
    check("lat_done", 32'(done), 1);
    check("lat_done_busy", 32'(busy), 0);
    @(negedge clk);
    check("lat_done_pulse", 32'(done), 0);
    check("lat_counts", 32'(xpulses - base), 0);
    ev_in = 1'b0;

    // Abort with start at count 0:4; an illegal start while busy is ignored
    @(posedge clk); #1;
    tgt_tens = 4'd2; tgt_units = 4'b1101; start = 1'b1; ev_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dbase = dones; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (busy && tens_cnt == 4'd0 && tb_res == 4'b0100) found = 1'b1;
      else begin
        start = busy && (tb_res == 4'b0010);
        tgt_units = 4'b0110;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check("abort_reached", 32'(found), 1);
    check("busy_start_err", 32'(err), 0);
    abort = 1'b1; start = 1'b1; ev_in = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_cnt_reset", 32'(cnt_reset), 1);
    check("abort_err", 32'(err), 0);
    @(negedge clk);
    check("abort_res", 32'(tb_res), 0);
    check("abort_busy2", 32'(busy), 0);
    check("abort_dones", 32'(dones - dbase), 0);

    // Reset mid-run
    @(posedge clk); #1;
    tgt_tens = 4'd1; tgt_units = 4'b0000; start = 1'b1; ev_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dbase = dones;
    repeat (5) @(posedge clk);
    #1;
    check("mid_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_cnt_reset", 32'(cnt_reset), 1);
    check("mid_tens", 32'(tens_cnt), 0);
    check("mid_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0; ev_in = 1'b0;
    @(negedge clk);
    check("mid_res", 32'(tb_res), 0);
    check("mid_busy2", 32'(busy), 0);
    check("mid_dones", 32'(dones - dbase), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
